// File: rtl/csr_file_m.sv
// csr_file_m -- machine-mode CSR file.
//   CSR read/write/set/clear, trap entry/exit bookkeeping, prioritised
//   interrupt selection and direct/vectored mtvec dispatch.
// Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle (B00/B80) and
//   minstret (B02/B82); without it those addresses are illegal.
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   csr_addr/op/wdata          CSR access (op: 00 none, 01 write, 10 set, 11 clear)
//   csr_rdata, csr_illegal     old CSR value for rd / access to unimplemented CSR
//   irq_msip/mtip/meip/local   interrupt levels, registered into mip
//   exc_valid/code/tval        synchronous exception
//   int_ack                    core takes the requested interrupt
//   trap_pc                    PC saved to mepc on trap
//   mret, instr_retire         trap return / retirement pulse
//   int_req, trap_vector       interrupt request and trap target PC
//   mepc_out                   mret target
module csr_file_m #(
  parameter int          NUM_LOCAL_IRQ = 16,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter bit          VECTORED      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        irq_msip,
  input  logic        irq_mtip,
  input  logic        irq_meip,
  input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic        int_ack,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        instr_retire,
  output logic        int_req,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out
);

  localparam logic [1:0] OP_NONE = 2'b00, OP_WRITE = 2'b01, OP_SET = 2'b10;

  function automatic logic [31:0] irq_mask_f();
    logic [31:0] m;
    m = 32'h0000_0888;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] IRQ_MASK  = irq_mask_f();
  // bit1 of mtvec never stored; bit0 only when vectored mode is supported
  localparam logic [31:0] TVEC_MASK = VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  logic [31:0] mstatus_rv;
  logic        addr_ok;
  logic [31:0] wval;
  logic        csr_en;
  logic [31:0] pend;
  logic [4:0]  int_cause;
  logic        take_int;
  logic [31:0] tvec_base;

  assign mstatus_rv = 32'h0000_1800 | {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  // Read mux / address decode
  always_comb begin
    csr_rdata = 32'h0;
    addr_ok   = 1'b1;
    case (csr_addr)
      12'h300: csr_rdata = mstatus_rv;
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_q;
`ifdef CSR_COUNTERS_EN
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      12'hB02: csr_rdata = minstret_q[31:0];
      12'hB82: csr_rdata = minstret_q[63:32];
`endif
      default: addr_ok = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != OP_NONE) && !addr_ok;

  always_comb begin
    case (csr_op)
      OP_WRITE: wval = csr_wdata;
      OP_SET:   wval = csr_rdata | csr_wdata;
      default:  wval = csr_rdata & ~csr_wdata;
    endcase
  end

  // Interrupt selection: later assignments win, so lowest priority goes first
  always_comb begin
    pend      = mip_q & mie_q;
    int_cause = 5'd0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++)
      if (pend[16+i]) int_cause = 5'(16 + i);
    if (pend[7])  int_cause = 5'd7;
    if (pend[3])  int_cause = 5'd3;
    if (pend[11]) int_cause = 5'd11;
  end

  assign int_req   = mstatus_mie_q && (pend != 32'h0);
  assign take_int  = int_ack && int_req;
  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign trap_vector = (!exc_valid && mtvec_q[0]) ? tvec_base + {25'b0, int_cause, 2'b00}
                                                  : tvec_base;
  assign mepc_out = mepc_q;

  // Set/clear with zero operand is a pure read; traps and mret suppress CSR writes
  assign csr_en = (csr_op != OP_NONE) && addr_ok && ((csr_op == OP_WRITE) || (csr_wdata != 32'h0))
                  && !exc_valid && !take_int && !mret;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mip_d          = 32'h0;
    mip_d[3]       = irq_msip;
    mip_d[7]       = irq_mtip;
    mip_d[11]      = irq_meip;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_d[16+i] = irq_local[i];
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instr_retire};
`endif

    if (exc_valid || take_int) begin
      mepc_d         = {trap_pc[31:2], 2'b00};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_d       = exc_valid ? {27'b0, exc_code} : {1'b1, 26'b0, int_cause};
      mtval_d        = exc_valid ? exc_tval : 32'h0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_en) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        12'h304: mie_d      = wval & IRQ_MASK;
        12'h305: mtvec_d    = wval & TVEC_MASK;
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = {wval[31:2], 2'b00};
        12'h342: mcause_d   = wval;
        12'h343: mtval_d    = wval;
`ifdef CSR_COUNTERS_EN
        // A written half replaces the whole counter update for that cycle
        12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wval};
        12'hB82: minstret_d = {wval, minstret_q[31:0]};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mip_q          <= 32'h0;
      mtvec_q        <= MTVEC_RESET & TVEC_MASK;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
`endif
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
module tb_csr_file_m;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        irq_msip, irq_mtip, irq_meip;
  logic [15:0] irq_local;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_tval;
  logic        int_ack;
  logic [31:0] trap_pc;
  logic        mret;
  logic        instr_retire;
  logic        int_req;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;

  int n_chk = 0;
  int n_pass = 0;

  csr_file_m #(.NUM_LOCAL_IRQ(16), .MTVEC_RESET(32'h0), .VECTORED(1'b1)) dut (
    .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
    .irq_meip(irq_meip), .irq_local(irq_local), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_tval(exc_tval), .int_ack(int_ack), .trap_pc(trap_pc), .mret(mret),
    .instr_retire(instr_retire), .int_req(int_req), .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // commit one clock edge, land 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_op = op; csr_addr = addr; csr_wdata = wd;
    step();
    csr_op = 2'b00; csr_wdata = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_op = 2'b00; csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 32'h0;
    irq_msip = 0; irq_mtip = 0; irq_meip = 0; irq_local = 16'h0;
    exc_valid = 0; exc_code = 5'd0; exc_tval = 32'h0; int_ack = 0;
    trap_pc = 32'h0; mret = 0; instr_retire = 0;
    step(); step();
    reset = 1'b0;

    // reset state
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mie", 12'h304, 32'h0);
    chk("rst_mepc_out", mepc_out, 32'h0);
    chk("rst_int_req", {31'b0, int_req}, 32'h0);

    // mtvec: bit1 forced 0, vectored mode kept
    csr(2'b01, 12'h305, 32'h8000_0103);
    rd("mtvec_bit1", 12'h305, 32'h8000_0101);
    csr(2'b01, 12'h305, 32'h8000_0101);
    rd("mtvec_rw", 12'h305, 32'h8000_0101);

    // write / set / clear
    csr(2'b01, 12'h340, 32'hDEAD_BEEF);
    csr(2'b10, 12'h340, 32'h0000_0010);
    rd("mscratch_set", 12'h340, 32'hDEAD_BEFF);
    csr(2'b11, 12'h340, 32'hDEAD_0000);
    rd("mscratch_clr", 12'h340, 32'h0000_BEFF);
    csr(2'b10, 12'h340, 32'h0);
    rd("mscratch_set0", 12'h340, 32'h0000_BEFF);

    // mip read-only
    csr(2'b01, 12'h344, 32'hFFFF_FFFF);
    rd("mip_ro", 12'h344, 32'h0);

    // illegal address
    csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h1234_5678;
    #1;
    chk("illegal_flag", {31'b0, csr_illegal}, 32'h1);
    chk("illegal_rdata", csr_rdata, 32'h0);
    step();
    csr_op = 2'b00;
    #1;
    chk("illegal_op0", {31'b0, csr_illegal}, 32'h0);
    rd("illegal_nochg", 12'h340, 32'h0000_BEFF);
`ifndef CSR_COUNTERS_EN
    csr_op = 2'b01; csr_addr = 12'hB00;
    #1;
    chk("nocnt_illegal", {31'b0, csr_illegal}, 32'h1);
    csr_op = 2'b00;
`endif

    // mie implemented bits
    csr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'hFFFF_0888);
    csr(2'b01, 12'h304, 32'h0000_0800);

    // machine external interrupt
    csr(2'b10, 12'h300, 32'h8);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    chk("no_irq", {31'b0, int_req}, 32'h0);
    irq_meip = 1'b1;
    #1;
    chk("irq_latency", {31'b0, int_req}, 32'h0);
    step();
    chk("irq_req", {31'b0, int_req}, 32'h1);
    chk("irq_vec", trap_vector, 32'h8000_012C);
    int_ack = 1'b1; trap_pc = 32'h40;
    step();
    int_ack = 1'b0;
    chk("int_mepc", mepc_out, 32'h40);
    rd("int_mcause", 12'h342, 32'h8000_000B);
    rd("int_mstatus", 12'h300, 32'h0000_1880);
    rd("int_mtval", 12'h343, 32'h0);
    chk("int_req_off", {31'b0, int_req}, 32'h0);

    // mret
    mret = 1'b1;
    step();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_mepc", mepc_out, 32'h40);
    chk("mret_req", {31'b0, int_req}, 32'h1);

    // exception beats interrupt ack
    exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'h1234; int_ack = 1'b1; trap_pc = 32'h80;
    #1;
    chk("exc_vec", trap_vector, 32'h8000_0100);
    step();
    exc_valid = 1'b0; int_ack = 1'b0;
    rd("exc_mcause", 12'h342, 32'h2);
    rd("exc_mtval", 12'h343, 32'h1234);
    chk("exc_mepc", mepc_out, 32'h80);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);

    // mret beats CSR write
    mret = 1'b1;
    csr(2'b01, 12'h340, 32'h1);
    mret = 1'b0;
    rd("mret_prio_scr", 12'h340, 32'h0000_BEFF);
    rd("mret_prio_st", 12'h300, 32'h0000_1888);

    // exception beats CSR write to mepc
    exc_valid = 1'b1; exc_code = 5'd5; exc_tval = 32'h0; trap_pc = 32'h100;
    csr(2'b01, 12'h341, 32'h5555);
    exc_valid = 1'b0;
    chk("exc_prio_mepc", mepc_out, 32'h100);
    rd("exc_prio_mcause", 12'h342, 32'h5);

    // mepc low bits forced 0
    csr(2'b01, 12'h341, 32'h1003);
    rd("mepc_align", 12'h341, 32'h1000);

    // interrupt priority and vectoring
    irq_meip = 1'b0; irq_local = 16'h0104;
    csr(2'b01, 12'h304, 32'hFFFF_FFFF);
    csr(2'b01, 12'h300, 32'h8);
    chk("loc_req", {31'b0, int_req}, 32'h1);
    chk("loc_vec", trap_vector, 32'h8000_0160);
    irq_mtip = 1'b1; step();
    chk("mti_vec", trap_vector, 32'h8000_011C);
    irq_msip = 1'b1; step();
    chk("msi_vec", trap_vector, 32'h8000_010C);
    irq_meip = 1'b1; step();
    chk("mei_vec", trap_vector, 32'h8000_012C);
    rd("mip_read", 12'h344, 32'h0104_0888);

    // direct mode
    csr(2'b01, 12'h305, 32'h2000_0000);
    chk("direct_vec", trap_vector, 32'h2000_0000);

    // int_ack without request
    csr(2'b01, 12'h300, 32'h0);
    chk("ack_noreq", {31'b0, int_req}, 32'h0);
    int_ack = 1'b1; trap_pc = 32'h999;
    step();
    int_ack = 1'b0;
    chk("ack_ign_mepc", mepc_out, 32'h1000);
    rd("ack_ign_mcause", 12'h342, 32'h5);

`ifdef CSR_COUNTERS_EN
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd("cyc_max_lo", 12'hB00, 32'hFFFF_FFFF);
    rd("cyc_max_hi", 12'hB80, 32'hFFFF_FFFF);
    step();
    rd("cyc_wrap_lo", 12'hB00, 32'h0);
    rd("cyc_wrap_hi", 12'hB80, 32'h0);
    csr(2'b01, 12'hB00, 32'h5);
    rd("cyc_wr", 12'hB00, 32'h5);
    step();
    rd("cyc_inc", 12'hB00, 32'h6);
    instr_retire = 1'b1;
    csr(2'b01, 12'hB02, 32'h10);
    rd("ret_wr", 12'hB02, 32'h10);
    step();
    instr_retire = 1'b0;
    rd("ret_inc", 12'hB02, 32'h11);
`endif

    // reset mid-run overrides everything
    reset = 1'b1; int_ack = 1'b1; exc_valid = 1'b1;
    step();
    reset = 1'b0; int_ack = 1'b0; exc_valid = 1'b0;
    chk("rst2_mepc", mepc_out, 32'h0);
    chk("rst2_req", {31'b0, int_req}, 32'h0);
    rd("rst2_mtvec", 12'h305, 32'h0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_mcause", 12'h342, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
